// File: rtl/reg_scoreboard_if.sv
// ============================================================================
// reg_scoreboard_if : decode/writeback <-> scoreboard signal bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface reg_scoreboard_if #(
  parameter int NUM_REGS = 32,
  parameter int AW       = $clog2(NUM_REGS)
);
  logic                flush;
  logic                id_valid;
  logic [AW-1:0]       rs1_addr;
  logic [AW-1:0]       rs2_addr;
  logic                rs1_rden;
  logic                rs2_rden;
  logic [AW-1:0]       rd_addr;
  logic                rd_wren;
  logic                id_long;
  logic                wb_valid;
  logic [AW-1:0]       wb_rd;
  logic                stall;
  logic [NUM_REGS-1:0] busy_vec;
  logic                long_busy;
  logic                long_done;
  logic [AW-1:0]       long_rd;

  modport master (
    output flush, id_valid, rs1_addr, rs2_addr, rs1_rden, rs2_rden,
           rd_addr, rd_wren, id_long, wb_valid, wb_rd,
    input  stall, busy_vec, long_busy, long_done, long_rd
  );

  modport slave (
    input  flush, id_valid, rs1_addr, rs2_addr, rs1_rden, rs2_rden,
           rd_addr, rd_wren, id_long, wb_valid, wb_rd,
    output stall, busy_vec, long_busy, long_done, long_rd
  );
endinterface

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// ============================================================================
// reg_scoreboard : decode-stage RAW/WAW/structural hazard controller with a
//                  single long-latency (div) unit tracker.
// Option macro: SCOREBOARD_BYPASS_EN (regfile write-through bypass on RAW).
// Revision 1.0
// ============================================================================
`default_nettype none

module reg_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int DIV_LAT  = 34,
  parameter int CNT_W    = $clog2(DIV_LAT)
) (
  input  wire logic       clk,
  input  wire logic       rst,
  reg_scoreboard_if.slave sb
);

  localparam int AW = $clog2(NUM_REGS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [AW-1:0]       long_rd_q, long_rd_nx;
  logic [NUM_REGS-1:0] busy, busy_nx;

  logic rs1_byp, rs2_byp;
  logic raw, waw, strc, stall, issue;

`ifdef SCOREBOARD_BYPASS_EN
  // Writeback writes through the regfile, so the retiring value is readable now.
  assign rs1_byp = sb.wb_valid && (sb.wb_rd == sb.rs1_addr);
  assign rs2_byp = sb.wb_valid && (sb.wb_rd == sb.rs2_addr);
`else
  assign rs1_byp = 1'b0;
  assign rs2_byp = 1'b0;
`endif

  assign raw = (sb.rs1_rden && (|sb.rs1_addr) && busy[sb.rs1_addr] && !rs1_byp) ||
               (sb.rs2_rden && (|sb.rs2_addr) && busy[sb.rs2_addr] && !rs2_byp);
  assign waw   = sb.rd_wren && (|sb.rd_addr) && busy[sb.rd_addr];
  assign strc  = sb.id_long && (state != S_IDLE);
  assign stall = sb.id_valid && (raw || waw || strc);
  assign issue = sb.id_valid && !stall && !sb.flush;

  always_comb begin
    busy_nx = busy;
    if (sb.wb_valid && (|sb.wb_rd))
      busy_nx[sb.wb_rd] = 1'b0;
    // Applied after the clear so a same-cycle set on the same register wins.
    if (issue && sb.rd_wren && (|sb.rd_addr))
      busy_nx[sb.rd_addr] = 1'b1;
    if (sb.flush)
      busy_nx = '0;
    busy_nx[0] = 1'b0;
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    long_rd_nx = long_rd_q;
    case (state)
      S_IDLE: begin
        if (issue && sb.id_long) begin
          state_nx   = S_RUN;
          cnt_nx     = CNT_LOAD;
          long_rd_nx = sb.rd_addr;
        end
      end
      S_RUN: begin
        if (cnt == '0)
          state_nx = S_DONE;
        else
          cnt_nx = cnt - 1'b1;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (sb.flush) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      long_rd_q <= '0;
      busy      <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      long_rd_q <= long_rd_nx;
      busy      <= busy_nx;
    end
  end

  assign sb.stall     = stall;
  assign sb.busy_vec  = busy;
  assign sb.long_busy = (state != S_IDLE);
  assign sb.long_done = (state == S_DONE);
  assign sb.long_rd   = long_rd_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
// ============================================================================
// tb_reg_scoreboard : directed self-checking bench for reg_scoreboard
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_reg_scoreboard;

`ifdef SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  reg_scoreboard_if #(.NUM_REGS(32)) sb ();

  reg_scoreboard #(.NUM_REGS(32), .DIV_LAT(34)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    sb.flush    = 1'b0;
    sb.id_valid = 1'b0;
    sb.rs1_addr = 5'd0;
    sb.rs2_addr = 5'd0;
    sb.rs1_rden = 1'b0;
    sb.rs2_rden = 1'b0;
    sb.rd_addr  = 5'd0;
    sb.rd_wren  = 1'b0;
    sb.id_long  = 1'b0;
    sb.wb_valid = 1'b0;
    sb.wb_rd    = 5'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    tick();
    tick();
    rst = 1'b0;
    #4;
    n_cmp++; if (sb.busy_vec !== 32'h0) begin n_fail++; $display("FAIL reset_busy got=%h exp=%h", sb.busy_vec, 32'h0); end
    n_cmp++; if (sb.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", sb.stall); end
    n_cmp++; if (sb.long_busy !== 1'b0) begin n_fail++; $display("FAIL reset_long_busy got=%b exp=0", sb.long_busy); end
    n_cmp++; if (sb.long_done !== 1'b0) begin n_fail++; $display("FAIL reset_long_done got=%b exp=0", sb.long_done); end
    n_cmp++; if (sb.long_rd !== 5'd0) begin n_fail++; $display("FAIL reset_long_rd got=%0d exp=0", sb.long_rd); end
    tick();
  endtask

  task automatic test_raw();
    sb.id_valid = 1'b1; sb.rd_wren = 1'b1; sb.rd_addr = 5'd5;
    #4;
    n_cmp++; if (sb.stall !== 1'b0) begin n_fail++; $display("FAIL raw_producer_stall got=%b exp=0", sb.stall); end
    tick();
    sb.rd_wren = 1'b0; sb.rd_addr = 5'd0; sb.rs1_addr = 5'd5; sb.rs1_rden = 1'b1;
    #4;
    n_cmp++; if (sb.busy_vec !== 32'h20) begin n_fail++; $display("FAIL raw_busy5 got=%h exp=%h", sb.busy_vec, 32'h20); end
    n_cmp++; if (sb.stall !== 1'b1) begin n_fail++; $display("FAIL raw_rs1_stall got=%b exp=1", sb.stall); end
    tick();
    sb.wb_valid = 1'b1; sb.wb_rd = 5'd5;
    #4;
    n_cmp++; if (sb.stall !== !BYP) begin n_fail++; $display("FAIL raw_wb_cycle_stall got=%b exp=%b", sb.stall, !BYP); end
    tick();
    sb.wb_valid = 1'b0; sb.wb_rd = 5'd0;
    #4;
    n_cmp++; if (sb.busy_vec !== 32'h0) begin n_fail++; $display("FAIL raw_cleared_busy got=%h exp=0", sb.busy_vec); end
    n_cmp++; if (sb.stall !== 1'b0) begin n_fail++; $display("FAIL raw_after_wb_stall got=%b exp=0", sb.stall); end
    tick();
    // rs2 path and read-enable gating
    drive_idle();
    sb.id_valid = 1'b1; sb.rd_wren = 1'b1; sb.rd_addr = 5'd12;
    tick();
    sb.rd_wren = 1'b0; sb.rd_addr = 5'd0;
    sb.rs1_addr = 5'd12; sb.rs2_addr = 5'd12;
    #4;
    n_cmp++; if (sb.stall !== 1'b0) begin n_fail++; $display("FAIL raw_rden_gate_stall got=%b exp=0", sb.stall); end
    tick();
    sb.rs2_rden = 1'b1;
    #4;
    n_cmp++; if (sb.stall !== 1'b1) begin n_fail++; $display("FAIL raw_rs2_stall got=%b exp=1", sb.stall); end
    tick();
    sb.wb_valid = 1'b1; sb.wb_rd = 5'd12;
    #4;
    n_cmp++; if (sb.stall !== !BYP) begin n_fail++; $display("FAIL raw_rs2_wb_stall got=%b exp=%b", sb.stall, !BYP); end
    tick();
    drive_idle();
    #4;
    n_cmp++; if (sb.busy_vec !== 32'h0) begin n_fail++; $display("FAIL raw_rs2_cleared got=%h exp=0", sb.busy_vec); end
    tick();
  endtask

  task automatic test_x0();
    sb.id_valid = 1'b1; sb.rd_wren = 1'b1; sb.rd_addr = 5'd0;
    sb.rs1_addr = 5'd0; sb.rs1_rden = 1'b1;
    #4;
    n_cmp++; if (sb.stall !== 1'b0) begin n_fail++; $display("FAIL x0_first_stall got=%b exp=0", sb.stall); end
    tick();
    #4;
    n_cmp++; if (sb.busy_vec !== 32'h0) begin n_fail++; $display("FAIL x0_busy got=%h exp=0", sb.busy_vec); end
    n_cmp++; if (sb.stall !== 1'b0) begin n_fail++; $display("FAIL x0_second_stall got=%b exp=0", sb.stall); end
    tick();
    drive_idle();
  endtask

  task automatic test_set_wins();
    sb.id_valid = 1'b1; sb.rd_wren = 1'b1; sb.rd_addr = 5'd3;
    sb.wb_valid = 1'b1; sb.wb_rd = 5'd3;
    #4;
    n_cmp++; if (sb.stall !== 1'b0) begin n_fail++; $display("FAIL setwin_issue_stall got=%b exp=0", sb.stall); end
    tick();
    sb.wb_valid = 1'b0; sb.wb_rd = 5'd0;
    #4;
    n_cmp++; if (sb.busy_vec !== 32'h8) begin n_fail++; $display("FAIL setwin_busy3 got=%h exp=%h", sb.busy_vec, 32'h8); end
    n_cmp++; if (sb.stall !== 1'b1) begin n_fail++; $display("FAIL setwin_waw_stall got=%b exp=1", sb.stall); end
    tick();
    sb.wb_valid = 1'b1; sb.wb_rd = 5'd3;
    #4;
    n_cmp++; if (sb.stall !== 1'b1) begin n_fail++; $display("FAIL waw_wb_cycle_stall got=%b exp=1", sb.stall); end
    tick();
    sb.wb_valid = 1'b0; sb.wb_rd = 5'd0;
    #4;
    n_cmp++; if (sb.busy_vec !== 32'h0) begin n_fail++; $display("FAIL waw_cleared got=%h exp=0", sb.busy_vec); end
    n_cmp++; if (sb.stall !== 1'b0) begin n_fail++; $display("FAIL waw_release_stall got=%b exp=0", sb.stall); end
    tick();
    // retire 3 while issuing 9: independent set and clear in one cycle
    sb.rd_addr = 5'd9; sb.wb_valid = 1'b1; sb.wb_rd = 5'd3;
    tick();
    drive_idle();
    sb.wb_valid = 1'b1; sb.wb_rd = 5'd9;
    #4;
    n_cmp++; if (sb.busy_vec !== 32'h200) begin n_fail++; $display("FAIL set_clear_mix got=%h exp=%h", sb.busy_vec, 32'h200); end
    tick();
    drive_idle();
    #4;
    n_cmp++; if (sb.busy_vec !== 32'h0) begin n_fail++; $display("FAIL set_clear_final got=%h exp=0", sb.busy_vec); end
    tick();
  endtask

  task automatic test_long();
    sb.id_valid = 1'b1; sb.id_long = 1'b1; sb.rd_wren = 1'b1; sb.rd_addr = 5'd7;
    #4;
    n_cmp++; if (sb.stall !== 1'b0) begin n_fail++; $display("FAIL long_issue_stall got=%b exp=0", sb.stall); end
    n_cmp++; if (sb.long_busy !== 1'b0) begin n_fail++; $display("FAIL long_t0_busy got=%b exp=0", sb.long_busy); end
    tick();
    for (int k = 1; k <= 35; k++) begin
      if (k == 1) drive_idle();
      if (k == 10) begin sb.id_valid = 1'b1; sb.id_long = 1'b1; end
      #4;
      n_cmp++; if (sb.long_busy !== 1'b1) begin n_fail++; $display("FAIL long_busy k=%0d got=%b exp=1", k, sb.long_busy); end
      n_cmp++; if (sb.long_done !== (k == 35)) begin n_fail++; $display("FAIL long_done k=%0d got=%b exp=%b", k, sb.long_done, (k == 35)); end
      n_cmp++; if (sb.long_rd !== 5'd7) begin n_fail++; $display("FAIL long_rd k=%0d got=%0d exp=7", k, sb.long_rd); end
      if (k >= 10) begin
        n_cmp++; if (sb.stall !== 1'b1) begin n_fail++; $display("FAIL long_strc_stall k=%0d got=%b exp=1", k, sb.stall); end
      end
      tick();
    end
    // T+36: unit free again; flush keeps the waiting op from actually starting
    sb.flush = 1'b1;
    #4;
    n_cmp++; if (sb.stall !== 1'b0) begin n_fail++; $display("FAIL long_t36_stall got=%b exp=0", sb.stall); end
    n_cmp++; if (sb.long_busy !== 1'b0) begin n_fail++; $display("FAIL long_t36_busy got=%b exp=0", sb.long_busy); end
    n_cmp++; if (sb.long_done !== 1'b0) begin n_fail++; $display("FAIL long_t36_done got=%b exp=0", sb.long_done); end
    n_cmp++; if (sb.busy_vec !== 32'h80) begin n_fail++; $display("FAIL long_keeps_busy7 got=%h exp=%h", sb.busy_vec, 32'h80); end
    tick();
    drive_idle();
    #4;
    n_cmp++; if (sb.busy_vec !== 32'h0) begin n_fail++; $display("FAIL long_flush_busy got=%h exp=0", sb.busy_vec); end
    n_cmp++; if (sb.long_busy !== 1'b0) begin n_fail++; $display("FAIL long_flush_fsm got=%b exp=0", sb.long_busy); end
    tick();
  endtask

  task automatic test_flush();
    bit seen;
    sb.id_valid = 1'b1; sb.id_long = 1'b1; sb.rd_wren = 1'b1; sb.rd_addr = 5'd7;
    tick();
    sb.id_long = 1'b0; sb.rd_addr = 5'd9;
    #4;
    n_cmp++; if (sb.stall !== 1'b0) begin n_fail++; $display("FAIL flush_issue9_stall got=%b exp=0", sb.stall); end
    tick();
    drive_idle();
    tick();
    tick();
    tick();
    // T+5: flush beats a same-cycle issue and writeback
    sb.flush = 1'b1; sb.id_valid = 1'b1; sb.rd_wren = 1'b1; sb.rd_addr = 5'd11;
    sb.wb_valid = 1'b1; sb.wb_rd = 5'd7;
    #4;
    n_cmp++; if (sb.busy_vec !== 32'h280) begin n_fail++; $display("FAIL flush_pre_busy got=%h exp=%h", sb.busy_vec, 32'h280); end
    n_cmp++; if (sb.long_busy !== 1'b1) begin n_fail++; $display("FAIL flush_pre_long got=%b exp=1", sb.long_busy); end
    tick();
    drive_idle();
    #4;
    n_cmp++; if (sb.busy_vec !== 32'h0) begin n_fail++; $display("FAIL flush_post_busy got=%h exp=0", sb.busy_vec); end
    n_cmp++; if (sb.long_busy !== 1'b0) begin n_fail++; $display("FAIL flush_post_long got=%b exp=0", sb.long_busy); end
    n_cmp++; if (sb.long_done !== 1'b0) begin n_fail++; $display("FAIL flush_post_done got=%b exp=0", sb.long_done); end
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      #4;
      if (sb.long_done !== 1'b0) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_no_done_pulse got=%b exp=0", seen); end
    tick();
  endtask

  task automatic test_reset_abort();
    bit seen;
    sb.id_valid = 1'b1; sb.id_long = 1'b1; sb.rd_wren = 1'b1; sb.rd_addr = 5'd4;
    tick();
    drive_idle();
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1; sb.flush = 1'b1;
    tick();
    rst = 1'b0; sb.flush = 1'b0;
    #4;
    n_cmp++; if (sb.long_busy !== 1'b0) begin n_fail++; $display("FAIL rstabort_long_busy got=%b exp=0", sb.long_busy); end
    n_cmp++; if (sb.busy_vec !== 32'h0) begin n_fail++; $display("FAIL rstabort_busy got=%h exp=0", sb.busy_vec); end
    n_cmp++; if (sb.long_rd !== 5'd0) begin n_fail++; $display("FAIL rstabort_long_rd got=%0d exp=0", sb.long_rd); end
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      #4;
      if (sb.long_done !== 1'b0) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstabort_no_done got=%b exp=0", seen); end
    tick();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    drive_idle();
    test_reset();
    test_raw();
    test_x0();
    test_set_wins();
    test_long();
    test_flush();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
